// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: run controller for the risc_v_soc simulation/FPGA harness.
//
// Releases the SoC reset a fixed number of cycles after arst drops. While the
// SoC runs, it can inject a periodic hold pattern, which is ORed with an
// external hold. End-of-test is a core write to TOHOST_ADDR. If no such write
// arrives within TIMEOUT_CYCLES run cycles, a watchdog timeout ends the run.
// In DONE the core is frozen with hold=1 and its reset stays released.
//
// Ports:
//   clk_100MHz  in   system clock, rising edge
//   arst        in   asynchronous active-high reset
//   ext_hold    in   external hold request
//   wr_en       in   core data-bus write strobe
//   wr_addr     in   [ADDR_W] core write address
//   wr_data     in   [DATA_W] core write data
//   soc_arst_n  out  registered active-low reset to risc_v_soc
//   hold        out  hold to risc_v_soc
//   running     out  high while in RUN
//   done        out  sticky, test finished (tohost or timeout)
//   pass        out  sticky, tohost write with data==1
//   fail        out  sticky, tohost write with data!=1
//   timeout     out  sticky, watchdog expired
//   exit_code   out  [DATA_W] latched tohost data
//   cycle_cnt   out  [CNT_W] RUN cycles elapsed (saturating)
module soc_run_ctrl #(
  parameter int unsigned        RST_CYCLES     = 2,
  parameter int unsigned        TIMEOUT_CYCLES = 400,
  parameter int unsigned        HOLD_PERIOD    = 16,
  parameter int unsigned        HOLD_LEN       = 0,
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned        CNT_W          = 32
) (
  input  logic              clk_100MHz,
  input  logic              arst,
  input  logic              ext_hold,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              soc_arst_n,
  output logic              hold,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned PH_W = (HOLD_PERIOD > 2) ? $clog2(HOLD_PERIOD) : 1;

  localparam logic [7:0]        RST_LAST  = 8'(RST_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(HOLD_PERIOD - 1);
  localparam logic [PH_W-1:0]   PH_LEN    = PH_W'(HOLD_LEN);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] PASS_CODE = DATA_W'(1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e            state_q,      state_d;
  logic [7:0]        rst_cnt_q,    rst_cnt_d;
  logic [PH_W-1:0]   phase_q,      phase_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              soc_arst_n_q, soc_arst_n_d;
  logic              done_q,       done_d;
  logic              pass_q,       pass_d;
  logic              fail_q,       fail_d;
  logic              timeout_q,    timeout_d;
  logic [DATA_W-1:0] exit_q,       exit_d;

  logic tohost_hit;
  logic inj_hold;

  assign tohost_hit = wr_en && (wr_addr == TOHOST_ADDR);
  assign inj_hold   = (HOLD_LEN != 0) && (phase_q < PH_LEN);

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state_q      <= ST_RST;
      rst_cnt_q    <= '0;
      phase_q      <= '0;
      cnt_q        <= '0;
      soc_arst_n_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      exit_q       <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      soc_arst_n_q <= soc_arst_n_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      exit_q       <= exit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    soc_arst_n_d = soc_arst_n_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    exit_d       = exit_q;

    unique case (state_q)
      ST_RST: begin
        // soc_arst_n rises on the same edge that enters RUN, so the SoC
        // sees reset released on its first RUN cycle.
        if (rst_cnt_q == RST_LAST) begin
          state_d      = ST_RUN;
          soc_arst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
        // A tohost hit takes priority over the watchdog in the same cycle.
        if (tohost_hit) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          exit_d  = wr_data;
          pass_d  = (wr_data == PASS_CODE);
          fail_d  = (wr_data != PASS_CODE);
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
      end
      default: state_d = ST_RST;
    endcase
  end

  always_comb begin
    hold = 1'b0;
    unique case (state_q)
      ST_RUN:  hold = inj_hold || ext_hold;
      ST_DONE: hold = 1'b1;
      default: hold = 1'b0;
    endcase
  end

  assign running    = (state_q == ST_RUN);
  assign soc_arst_n = soc_arst_n_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign exit_code  = exit_q;
  assign cycle_cnt  = cnt_q;

endmodule
